// File: rtl/lane_gather_8.sv
// lane_gather_8
// Serial-to-parallel gather stage in front of the 8-port reduction block.
// Words arrive one per in_valid/in_ready handshake and are packed into lanes
// a..h in arrival order. A group closes when the eighth word lands or when
// flush is seen with at least one word in the group. Lanes that never received
// a word hold all-ones so they do not disturb the downstream AND. The packed
// group, its AND reduction (q) and its real word count (cnt) are then held on
// out_valid/out_ready until taken. Filling and draining never overlap.
module lane_gather_8 #(
  parameter int WIDTH    = 7,
  parameter int Port_Num = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] q,
  output logic [3:0]       cnt
);

  // Port_Num only has meaning for the downstream reduction instance; reject
  // a nonsensical value at elaboration so a bad parent configuration is caught.
  if (Port_Num < 1) begin : g_port_num_bad
    $error("lane_gather_8: Port_Num must be at least 1");
  end

  localparam logic [WIDTH-1:0] LANE_ONES = {WIDTH{1'b1}};
  localparam logic [3:0]       LAST_IDX  = 4'd7;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_r;
  logic [3:0]       idx_r;
  logic [WIDTH-1:0] lane_r [8];
  logic [WIDTH-1:0] q_r;
  logic [3:0]       cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             close_s;
  logic [3:0]       next_idx_s;
  logic [WIDTH-1:0] lane_next_s [8];
  logic [8*WIDTH-1:0] lanes_flat_s;
  logic             all_ones_s;

  // AND of every bit of every lane: 1 only when all eight lanes are all-ones.
  function automatic logic lanes_all_ones(input logic [8*WIDTH-1:0] flat);
    return &flat;
  endfunction

  // Handshake decode and group-close decision for the current cycle.
  always_comb begin
    accept_s   = 1'b0;
    close_s    = 1'b0;
    next_idx_s = idx_r;
    if (state_r == FILL) begin
      accept_s   = in_valid;
      next_idx_s = idx_r + {3'b000, in_valid};
      // A lone flush on an empty group is dropped so no empty group is emitted.
      close_s    = (in_valid && (idx_r == LAST_IDX)) ||
                   (flush && ((idx_r != 4'd0) || in_valid));
    end else begin
      accept_s   = 1'b0;
      close_s    = 1'b0;
      next_idx_s = idx_r;
    end
  end

  // Next lane contents: store the accepted word, pad unwritten lanes on close.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (accept_s && (idx_r == 4'(i))) begin
        lane_next_s[i] = in_data;
      end else if (close_s && (4'(i) >= next_idx_s)) begin
        lane_next_s[i] = LANE_ONES;
      end else begin
        lane_next_s[i] = lane_r[i];
      end
    end
  end

  // Flatten the next lanes so q is taken from exactly what gets registered.
  always_comb begin
    lanes_flat_s = '0;
    for (int i = 0; i < 8; i++) begin
      lanes_flat_s[i*WIDTH +: WIDTH] = lane_next_s[i];
    end
    all_ones_s = lanes_all_ones(lanes_flat_s);
  end

  // Gather state machine with registered handshake flags, lanes, q and cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= FILL;
      idx_r       <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_r         <= '0;
      cnt_r       <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        lane_r[i] <= LANE_ONES;
      end
    end else begin
      case (state_r)
        FILL: begin
          for (int i = 0; i < 8; i++) begin
            lane_r[i] <= lane_next_s[i];
          end
          idx_r <= next_idx_s;
          if (close_s) begin
            state_r     <= HOLD;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            q_r         <= WIDTH'(all_ones_s);
            cnt_r       <= next_idx_s;
          end
        end
        HOLD: begin
          // Lanes, q and cnt are left untouched until the group is taken.
          if (out_ready) begin
            state_r     <= FILL;
            idx_r       <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
              lane_r[i] <= LANE_ONES;
            end
          end
        end
        default: begin
          state_r     <= FILL;
          idx_r       <= 4'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          for (int i = 0; i < 8; i++) begin
            lane_r[i] <= LANE_ONES;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign a         = lane_r[0];
  assign b         = lane_r[1];
  assign c         = lane_r[2];
  assign d         = lane_r[3];
  assign e         = lane_r[4];
  assign f         = lane_r[5];
  assign g         = lane_r[6];
  assign h         = lane_r[7];
  assign q         = q_r;
  assign cnt       = cnt_r;

endmodule

// File: tb/tb_lane_gather_8.sv
// tb_lane_gather_8
// Directed bench for lane_gather_8 (WIDTH=7). A queue-based model of the
// gather rules predicts every held group; a negedge process compares the DUT
// against it each cycle, and the directed sequences add literal expectations.
module tb_lane_gather_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] a, b, c, d, e, f, g, h, q;
  logic [3:0] cnt;

  int n_checks = 0;
  int n_errors = 0;
  int groups_seen = 0;

  lane_gather_8 #(.WIDTH(7), .Port_Num(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .q(q), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] words[$];
  bit         holding = 1'b0;
  bit         model_live = 1'b0;
  logic [6:0] exp_lane [8];
  int         exp_cnt;
  bit         exp_q;

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      words.delete();
      holding    = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (!holding) begin
        if (in_valid) words.push_back(in_data);
        if (words.size() == 8 || (flush && words.size() > 0)) begin
          exp_q   = 1'b1;
          exp_cnt = words.size();
          for (int i = 0; i < 8; i++) begin
            exp_lane[i] = (i < words.size()) ? words[i] : 7'h7F;
            if (exp_lane[i] != 7'h7F) exp_q = 1'b0;
          end
          holding = 1'b1;
          words.delete();
        end
      end else if (out_ready) begin
        holding = 1'b0;
      end
    end
  end

  // count groups actually handed downstream
  always @(posedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) groups_seen++;
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (model_live) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, holding});
      check("in_ready", {31'd0, in_ready}, {31'd0, !holding});
      if (holding) begin
        check("lane_a", {25'd0, a}, {25'd0, exp_lane[0]});
        check("lane_b", {25'd0, b}, {25'd0, exp_lane[1]});
        check("lane_c", {25'd0, c}, {25'd0, exp_lane[2]});
        check("lane_d", {25'd0, d}, {25'd0, exp_lane[3]});
        check("lane_e", {25'd0, e}, {25'd0, exp_lane[4]});
        check("lane_f", {25'd0, f}, {25'd0, exp_lane[5]});
        check("lane_g", {25'd0, g}, {25'd0, exp_lane[6]});
        check("lane_h", {25'd0, h}, {25'd0, exp_lane[7]});
        check("q", {25'd0, q}, {31'd0, exp_q});
        check("cnt", {28'd0, cnt}, 32'(exp_cnt));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] wd, input logic fl);
    in_valid = 1'b1;
    in_data  = wd;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic flush_only();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a"}, {25'd0, a}, 32'h7F);
    check({tag, "_h"}, {25'd0, h}, 32'h7F);
    check({tag, "_q"}, {25'd0, q}, 32'h0);
    check({tag, "_cnt"}, {28'd0, cnt}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int g0;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 7'h00;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    // Full group of 7F: out_valid one cycle after the 8th accept
    for (int i = 0; i < 8; i++) send(7'h7F, 1'b0);
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_q", {25'd0, q}, 32'h1);
    check("full_cnt", {28'd0, cnt}, 32'd8);
    check("full_a", {25'd0, a}, 32'h7F);
    check("full_h", {25'd0, h}, 32'h7F);
    tick();
    check("full_drained", {31'd0, out_valid}, 32'd0);
    check("full_ready_back", {31'd0, in_ready}, 32'd1);

    // One zero bit in lane d
    for (int i = 0; i < 8; i++) send((i == 3) ? 7'h7E : 7'h7F, 1'b0);
    check("zero_q", {25'd0, q}, 32'h0);
    check("zero_d", {25'd0, d}, 32'h7E);
    check("zero_cnt", {28'd0, cnt}, 32'd8);
    tick();

    // Partial group closed by a lone flush
    for (int i = 0; i < 3; i++) send(7'h7F, 1'b0);
    flush_only();
    check("pflush_valid", {31'd0, out_valid}, 32'd1);
    check("pflush_cnt", {28'd0, cnt}, 32'd3);
    check("pflush_d", {25'd0, d}, 32'h7F);
    check("pflush_h", {25'd0, h}, 32'h7F);
    check("pflush_q", {25'd0, q}, 32'h1);
    tick();

    // Flush arriving with the third word
    send(7'h7F, 1'b0);
    send(7'h7F, 1'b0);
    send(7'h00, 1'b1);
    check("wflush_cnt", {28'd0, cnt}, 32'd3);
    check("wflush_c", {25'd0, c}, 32'h00);
    check("wflush_q", {25'd0, q}, 32'h0);
    tick();

    // Backpressure for 5 cycles; flush and in_valid must be ignored meanwhile
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(7'(i * 13 + 5), 1'b0);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_a", {25'd0, a}, 32'h05);
    check("bp_b", {25'd0, b}, 32'h12);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 7'h00;
      flush    = 1'b1;
      tick();
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_h", {25'd0, h}, 32'h60);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);

    // Empty flush is ignored; next group starts at lane a
    flush_only();
    check("eflush_valid", {31'd0, out_valid}, 32'd0);
    check("eflush_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) send(7'(8'h40 + i), 1'b0);
    check("eflush_a", {25'd0, a}, 32'h40);
    check("eflush_h", {25'd0, h}, 32'h47);
    check("eflush_cnt", {28'd0, cnt}, 32'd8);
    tick();

    // Reset mid-fill discards the partial group
    g0 = groups_seen;
    for (int i = 0; i < 4; i++) send(7'h11, 1'b0);
    rst_n = 1'b0;
    tick();
    check_reset_state("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(7'(8'h20 + i), 1'b0);
    check("midrst_a", {25'd0, a}, 32'h20);
    check("midrst_e", {25'd0, e}, 32'h24);
    check("midrst_cnt", {28'd0, cnt}, 32'd8);
    tick();
    repeat (3) tick();
    check("midrst_groups", 32'(groups_seen - g0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
